// File: rtl/stopwatch_control_if.sv
// Debounced button pulses in, registered BCD display digits and status out.
interface stopwatch_control_if;
  logic       start_stop_pulse;
  logic       clear_pulse;
  logic       lap_pulse;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] csec_tens;
  logic [3:0] csec_ones;
  logic       running;
  logic       lap_active;
  logic       overflow;

  modport master (
    output start_stop_pulse, clear_pulse, lap_pulse,
    input  sec_tens, sec_ones, csec_tens, csec_ones,
    input  running, lap_active, overflow
  );

  modport slave (
    input  start_stop_pulse, clear_pulse, lap_pulse,
    output sec_tens, sec_ones, csec_tens, csec_ones,
    output running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_control.sv
// Stopwatch run/pause/lap FSM, centisecond prescaler and SS.cc BCD counter
// with registered display digits and status flags.
module stopwatch_control #(
  parameter int unsigned TICK_DIVISOR  = 1000000,
  parameter int unsigned PRESCALE_BITS = 20
) (
  input logic                clk,
  input logic                rst_n,
  stopwatch_control_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] so;
    logic [3:0] ct;
    logic [3:0] co;
  } bcd_t;

  localparam logic [PRESCALE_BITS-1:0] PRE_MAX =
    PRESCALE_BITS'(TICK_DIVISOR - 1);

  state_e                   state_q, state_d;
  logic [PRESCALE_BITS-1:0] pre_q, pre_d;
  bcd_t                     cnt_q, cnt_d;
  bcd_t                     lap_q, lap_d;
  bcd_t                     disp_q, disp_d;
  logic                     ovf_q, ovf_d;
  logic                     ovf_o_q;
  logic                     run_q, run_d;
  logic                     lapo_q, lapo_d;
  logic                     clr, ss, lp;
  logic                     live, tick;

  // Priority clear > start_stop > lap; losers are dropped.
  assign clr  = sw.clear_pulse;
  assign ss   = sw.start_stop_pulse & ~clr;
  assign lp   = sw.lap_pulse & ~clr & ~sw.start_stop_pulse;
  assign live = (state_q == RUN) || (state_q == LAP);
  assign tick = live && (pre_q == PRE_MAX);

  function automatic bcd_t bcd_inc(bcd_t c);
    bcd_t n;
    n = c;
    if (c.co != 4'd9) begin
      n.co = c.co + 4'd1;
    end else begin
      n.co = 4'd0;
      if (c.ct != 4'd9) begin
        n.ct = c.ct + 4'd1;
      end else begin
        n.ct = 4'd0;
        if (c.so != 4'd9) begin
          n.so = c.so + 4'd1;
        end else begin
          n.so = 4'd0;
          n.st = (c.st == 4'd5) ? 4'd0 : c.st + 4'd1;
        end
      end
    end
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      clr: state_d = IDLE;
      ss:  state_d = live ? PAUSE : RUN;
      lp: begin
        if (state_q == RUN) begin
          state_d = LAP;
        end else if (state_q == LAP) begin
          state_d = RUN;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    disp_d = (state_q == LAP) ? lap_q : cnt_q;
    run_d  = live;
    lapo_d = (state_q == LAP);
  end

  // A tick on the same edge as a move to PAUSE still counts.
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    lap_d = lap_q;
    ovf_d = ovf_q;
    if (clr) begin
      pre_d = '0;
      cnt_d = '0;
      lap_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (tick) begin
        pre_d = '0;
        cnt_d = bcd_inc(cnt_q);
        if (cnt_q == 16'h5999) begin
          ovf_d = 1'b1;
        end
      end else if (live) begin
        pre_d = pre_q + 1'b1;
      end
      if (lp && state_q == RUN) begin
        lap_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
      run_q   <= 1'b0;
      lapo_q  <= 1'b0;
      ovf_o_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      run_q   <= run_d;
      lapo_q  <= lapo_d;
      ovf_o_q <= ovf_q;
    end
  end

  assign sw.sec_tens   = disp_q.st;
  assign sw.sec_ones   = disp_q.so;
  assign sw.csec_tens  = disp_q.ct;
  assign sw.csec_ones  = disp_q.co;
  assign sw.running    = run_q;
  assign sw.lap_active = lapo_q;
  assign sw.overflow   = ovf_o_q;

endmodule
